// File: rtl/bp_pkg.sv
// Shared branch-predictor types: counter encoding, update record, default address width.
package bp_pkg;

  localparam int unsigned BP_ADDR_W = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic [BP_ADDR_W-1:0] pc;
    logic                 taken;
    logic [BP_ADDR_W-1:0] target;
  } bp_update_t;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } bp_rr_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Generic DEPTH x W in-order queue with push/pop/clear; clear wins over push and pop.
module bp_update_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/bp_update_scheduler.sv
// Round-robin merge of branch-ALU and jump-unit training updates into the predictor port.
// Optional statistics counters are enabled with `define BP_UPD_STATS_EN.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = BP_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [ADDR_W-1:0]      req0_pc,
  input  logic                   req0_taken,
  input  logic [ADDR_W-1:0]      req0_target,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ADDR_W-1:0]      req1_pc,
  input  logic                   req1_taken,
  input  logic [ADDR_W-1:0]      req1_target,
  input  logic                   sched_pause,
  input  logic                   sched_flush,
  output logic                   upd_enable,
  output logic [ADDR_W-1:0]      upd_pc,
  output logic                   upd_taken,
  output logic [ADDR_W-1:0]      upd_target,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]            stat_updates,
  output logic [31:0]            stat_flushed
`endif
);
  localparam int unsigned W = 2 * ADDR_W + 1;

  bp_rr_t        rr, rr_next;
  logic          grant0, grant1, xfer0, xfer1, push;
  logic          full, empty;
  logic [W-1:0]  din, head;
  logic [ADDR_W-1:0] head_pc, head_target;
  logic          head_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr <= RR_REQ0;
    else        rr <= rr_next;
  end

  // Full blocks both sources even when a drain happens in the same cycle.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    rr_next = rr;
    if (req0_valid && (!req1_valid || rr == RR_REQ0)) grant0 = 1'b1;
    else if (req1_valid)                                grant1 = 1'b1;
    req0_ready = grant0 && !full && !sched_flush;
    req1_ready = grant1 && !full && !sched_flush;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
    push       = xfer0 || xfer1;
    if (xfer0)      rr_next = RR_REQ1;
    else if (xfer1) rr_next = RR_REQ0;
    din = xfer0 ? {req0_pc, req0_taken, req0_target}
                : {req1_pc, req1_taken, req1_target};
  end

  bp_update_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (upd_enable),
    .clear (sched_flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign {head_pc, head_taken, head_target} = head;
  assign upd_enable = !empty && !sched_pause && !sched_flush;
  assign upd_pc     = upd_enable ? head_pc     : '0;
  assign upd_taken  = upd_enable ? head_taken  : 1'b0;
  assign upd_target = upd_enable ? head_target : '0;

`ifdef BP_UPD_STATS_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, stat_flushed} + 33'(occupancy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_flushed <= '0;
    end else begin
      if (upd_enable && stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (sched_flush) stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs.
module tb_bp_update_scheduler;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_pc = '0, req0_target = '0, req1_pc = '0, req1_target = '0;
  logic        req0_taken = 1'b0, req1_taken = 1'b0;
  logic        sched_pause = 1'b0, sched_flush = 1'b0;
  logic        upd_enable, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [2:0]  occupancy;
`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_updates, stat_flushed;
`endif

  bp_update_scheduler #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
    .req0_taken(req0_taken), .req0_target(req0_target),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
    .req1_taken(req1_taken), .req1_target(req1_target),
    .sched_pause(sched_pause), .sched_flush(sched_flush),
    .upd_enable(upd_enable), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .occupancy(occupancy)
`ifdef BP_UPD_STATS_EN
    , .stat_updates(stat_updates), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tg;
  } upd_t;

  typedef struct {
    bit          en, r0, r1;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tg;
    int          occ;
    longint      su, sf;
  } exp_t;

  upd_t   mq[$];
  exp_t   sb[$];
  int     rr = 0;
  longint m_su = 0, m_sf = 0;
  upd_t   p0, p1;
  bit     pend0 = 0, pend1 = 0;
  int     n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic upd_t rnd();
    upd_t u;
    u.pc = $urandom;
    u.tk = 1'($urandom_range(0, 1));
    u.tg = $urandom;
    return u;
  endfunction

  function automatic longint sat32(input longint x);
    return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
  endfunction

  // Monitor: compares whatever the model promised for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("req0_ready", req0_ready, e.r0);
        chk("req1_ready", req1_ready, e.r1);
        chk("upd_enable", upd_enable, e.en);
        chk("upd_pc", upd_pc, e.pc);
        chk("upd_taken", upd_taken, e.tk);
        chk("upd_target", upd_target, e.tg);
        chk("occupancy", occupancy, e.occ);
`ifdef BP_UPD_STATS_EN
        chk("stat_updates", stat_updates, e.su);
        chk("stat_flushed", stat_flushed, e.sf);
`endif
      end
    end
  end

  task automatic cyc(input bit v0, input bit v1, input bit pause, input bit flush);
    exp_t e;
    bit   full, g0, g1;
    @(negedge clk);
    req0_valid = v0; req0_pc = p0.pc; req0_taken = p0.tk; req0_target = p0.tg;
    req1_valid = v1; req1_pc = p1.pc; req1_taken = p1.tk; req1_target = p1.tg;
    sched_pause = pause; sched_flush = flush;
    #1;
    full = (mq.size() == DEPTH);
    g0   = v0 && (!v1 || rr == 0);
    g1   = v1 && !g0;
    e.r0 = g0 && !full && !flush;
    e.r1 = g1 && !full && !flush;
    e.en = (mq.size() > 0) && !pause && !flush;
    e.pc = e.en ? mq[0].pc : 32'h0;
    e.tk = e.en ? mq[0].tk : 1'b0;
    e.tg = e.en ? mq[0].tg : 32'h0;
    e.occ = mq.size();
    e.su = m_su;
    e.sf = m_sf;
    sb.push_back(e);
    if (flush) begin
      m_sf = sat32(m_sf + mq.size());
      mq.delete();
    end else begin
      if (e.en) begin
        void'(mq.pop_front());
        m_su = sat32(m_su + 1);
      end
      if (e.r0) begin mq.push_back(p0); rr = 1; p0 = rnd(); end
      if (e.r1) begin mq.push_back(p1); rr = 0; p1 = rnd(); end
    end
    pend0 = v0 && !e.r0;
    pend1 = v1 && !e.r1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p0 = rnd();
    p1 = rnd();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_upd_enable", upd_enable, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_upd_pc", upd_pc, 0);
    chk("reset_readys", {req0_ready, req1_ready}, 0);

    // single update, one-cycle latency, one-cycle pulse
    p0.pc = 32'h100; p0.tk = 1'b1; p0.tg = 32'h200;
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // contention under pause fills the queue, then it stalls both sources
    repeat (5) cyc(1, 1, 1, 0);
    // release pause: four drains in order
    repeat (5) cyc(0, 0, 0, 0);

    // flush at occupancy 3 with a waiting requester
    repeat (3) cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);

    // steady single-source stream
    repeat (10) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // reset mid-drain
    repeat (2) cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_upd_enable", upd_enable, 0);
    chk("async_rst_upd_pc", upd_pc, 0);
    chk("async_rst_occupancy", occupancy, 0);
    mq.delete(); rr = 0; m_su = 0; m_sf = 0; pend0 = 0; pend1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit v0, v1, pz, fl;
      v0 = pend0 || ($urandom_range(0, 99) < 60);
      v1 = pend1 || ($urandom_range(0, 99) < 60);
      pz = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 4);
      cyc(v0, v1, pz, fl);
    end
    repeat (8) cyc(0, 0, 0, 0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
